lane_sipo: RTL and testbench
============================

LANE_SIPO -- requirements
Module: lane_sipo

Interface
REQ-001 Parameter IN_BITS, default 1: width of one input beat (lane); SHALL be >= 1.
REQ-002 Parameter BEATS, default 8: beats per output word; SHALL be >= 2. OUT_BITS = IN_BITS*BEATS; CNT_BITS = $clog2(BEATS+1).
REQ-003 Parameter MSB_FIRST, default 1: 1 = first beat lands in the most-significant lane; 0 = first beat lands in lane 0.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst  input  1  reset; one clock, asynchronous, active-low.
REQ-006 input_valid  input  1  input beat offered.
REQ-007 input_data  input  IN_BITS  input beat.
REQ-008 input_ready  output  1  beat accepted on an edge where input_valid & input_ready.
REQ-009 input_last  input  1  accepted beat closes the current word (LANE_SIPO_LAST_EN builds only).
REQ-010 output_valid  output  1  output word held.
REQ-011 output_data  output  OUT_BITS  assembled word.
REQ-012 output_ready  input  1  word consumed on an edge where output_valid & output_ready.
REQ-013 output_count  output  CNT_BITS  beats in output word (LANE_SIPO_LAST_EN builds only).

Function
REQ-014 Block SHALL hold two stages: an assembly register with beat counter cnt (0..BEATS-1) and full flag asm_full, and an output register with flag output_valid.
REQ-015 Lane position of accepted beat k (0-based): MSB_FIRST=1 -> bits [OUT_BITS-1-k*IN_BITS -: IN_BITS]; MSB_FIRST=0 -> bits [k*IN_BITS +: IN_BITS].
REQ-016 On acceptance: beat written to lane cnt; cnt increments; on the BEATS-th beat cnt wraps to 0 and asm_full sets.
REQ-017 out_free = !output_valid | output_ready. input_ready = !asm_full | out_free (combinational from output_ready; no path from input_valid/input_last).
REQ-018 Transfer: on an edge where asm_full & out_free, the assembly word (and count) SHALL move to the output register, output_valid sets, asm_full clears, assembly lanes clear to zero.
REQ-019 A beat accepted on the same edge as a transfer SHALL land in lane 0 position of the fresh word (not be lost or merged into the departing word).
REQ-020 Latency: completing beat accepted at edge E -> output_valid high after edge E+1 when out_free at E+1; full-word throughput SHALL be one beat per cycle when output_ready is held high.
REQ-021 Consume with no transfer on the same edge SHALL clear output_valid; output_data SHALL hold stable while output_valid & !output_ready.
REQ-022 Unfilled lanes of any word SHALL read zero.
REQ-023 input_valid with input_ready low SHALL change no state.

Reset
REQ-024 While rst low (asynchronously): cnt=0, asm_full=0, output_valid=0, output_data=0, output_count=0, assembly lanes=0; input_ready SHALL read 1.
REQ-025 Reset assertion mid-word SHALL discard the partial word and any held output; first beat after release SHALL start a new word.

Configuration
REQ-026 Macro LANE_SIPO_LAST_EN defined: input_last and output_count exist; accepted beat with input_last=1 SHALL set asm_full after writing its lane, with count = cnt+1, cnt returns to 0; full words report count = BEATS; input_last on the BEATS-th beat SHALL behave as a normal full word.
REQ-027 Macro undefined: input_last and output_count ports SHALL be absent; words complete only after BEATS beats.

Verification
REQ-028 IN_BITS=1, BEATS=8, MSB_FIRST=1, output_ready=1, bits 1,0,1,1,0,0,1,0 back-to-back -> output_data=8'hB2 one cycle after 8th beat, output_valid for exactly one cycle.
REQ-029 Same stream with MSB_FIRST=0 -> output_data=8'h4D.
REQ-030 IN_BITS=4, BEATS=2, output_ready=0, stream 4'hA,4'h5,4'h3,4'hC -> output holds 8'hA5, assembly full with 8'h3C, input_ready=0; raise output_ready for one cycle -> 8'hA5 consumed, 8'h3C presented next cycle, input_ready=1.
REQ-031 LANE_SIPO_LAST_EN, IN_BITS=1, BEATS=8, MSB_FIRST=1: beats 1,1,1 with input_last on third -> output_data=8'hE0, output_count=3; next full word reports count 8.
REQ-032 Reset asserted after 5 of 8 beats with output word held -> output_valid=0, output_data=0 immediately; 8 fresh beats of 1 -> output_data=8'hFF.
REQ-033 Continuous input_valid=1, output_ready=1 for 64 beats (BEATS=8) -> 8 words, input_ready never low.

Source files
------------

// File: rtl/lane_sipo.sv
// lane_sipo: serial-in / parallel-out lane packer with a two-deep buffer
// (assembly register + output register). Beats of IN_BITS are gathered into
// words of BEATS lanes and handed off over a valid/ready output.
// Optional feature macro: LANE_SIPO_LAST_EN adds input_last (early word
// close) and output_count (beats held in the presented word).
module lane_sipo #(
  parameter int IN_BITS   = 1,
  parameter int BEATS     = 8,
  parameter int MSB_FIRST = 1,
  localparam int OUT_BITS = IN_BITS * BEATS,
  localparam int CNT_BITS = $clog2(BEATS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                input_valid,
  input  logic [IN_BITS-1:0]  input_data,
  output logic                input_ready,
`ifdef LANE_SIPO_LAST_EN
  input  logic                input_last,
  output logic [CNT_BITS-1:0] output_count,
`endif
  output logic                output_valid,
  output logic [OUT_BITS-1:0] output_data,
  input  logic                output_ready
);

  // Writes one beat into lane k of a word; lane order follows MSB_FIRST.
  function automatic logic [OUT_BITS-1:0] place_beat(
    input logic [OUT_BITS-1:0] word,
    input logic [CNT_BITS-1:0] k,
    input logic [IN_BITS-1:0]  beat
  );
    logic [OUT_BITS-1:0] w;
    w = word;
    for (int i = 0; i < BEATS; i++) begin
      if (k == CNT_BITS'(i)) begin
        if (MSB_FIRST != 0) w[OUT_BITS-1-i*IN_BITS -: IN_BITS] = beat;
        else                w[i*IN_BITS +: IN_BITS] = beat;
      end
    end
    return w;
  endfunction

  // Stage p0: assembly register
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic                asm_full, asm_full_nxt;
  logic [OUT_BITS-1:0] asm_data_p0, asm_data_nxt;
`ifdef LANE_SIPO_LAST_EN
  logic [CNT_BITS-1:0] asm_count_p0, asm_count_nxt;
`endif

  logic out_free;
  logic accept;
  logic xfer;
  logic beat_done;

  // The output register frees up either because it is empty or because it is
  // being consumed on this very edge, so a full assembly word can move over
  // without a bubble. input_ready depends only on state and output_ready.
  assign out_free    = !output_valid || output_ready;
  assign input_ready = !asm_full || out_free;
  assign accept      = input_valid && input_ready;
  assign xfer        = asm_full && out_free;

`ifdef LANE_SIPO_LAST_EN
  assign beat_done = (cnt == CNT_BITS'(BEATS - 1)) || input_last;
`else
  assign beat_done = (cnt == CNT_BITS'(BEATS - 1));
`endif

  // Next assembly state: a departing word clears the lanes first, so a beat
  // accepted on the transfer edge lands as the first beat of a fresh word
  // (cnt is already 0 whenever asm_full is set).
  always_comb begin
    asm_data_nxt = xfer ? '0 : asm_data_p0;
    cnt_nxt      = cnt;
    asm_full_nxt = asm_full && !xfer;
`ifdef LANE_SIPO_LAST_EN
    asm_count_nxt = asm_count_p0;
`endif
    if (accept) begin
      asm_data_nxt = place_beat(asm_data_nxt, cnt, input_data);
      if (beat_done) begin
        cnt_nxt      = '0;
        asm_full_nxt = 1'b1;
`ifdef LANE_SIPO_LAST_EN
        asm_count_nxt = cnt + CNT_BITS'(1);
`endif
      end else begin
        cnt_nxt = cnt + CNT_BITS'(1);
      end
    end
  end

  // Assembly register update; reset drops any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      asm_full     <= 1'b0;
      asm_data_p0  <= '0;
`ifdef LANE_SIPO_LAST_EN
      asm_count_p0 <= '0;
`endif
    end else begin
      cnt          <= cnt_nxt;
      asm_full     <= asm_full_nxt;
      asm_data_p0  <= asm_data_nxt;
`ifdef LANE_SIPO_LAST_EN
      asm_count_p0 <= asm_count_nxt;
`endif
    end
  end

  // Stage p1: output register
  // Loads on transfer, drops valid on a bare consume, otherwise holds steady.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      output_valid <= 1'b0;
      output_data  <= '0;
`ifdef LANE_SIPO_LAST_EN
      output_count <= '0;
`endif
    end else if (xfer) begin
      output_valid <= 1'b1;
      output_data  <= asm_data_p0;
`ifdef LANE_SIPO_LAST_EN
      output_count <= asm_count_p0;
`endif
    end else if (output_ready) begin
      output_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_sipo.sv
// tb_lane_sipo: directed bench for lane_sipo. Three instances share clk/rst:
// u_a (1x8 MSB-first) and u_b (1x8 LSB-first) see the same beat stream,
// u_c (4x2 MSB-first) is driven on its own. Define LANE_SIPO_LAST_EN to also
// cover early word close and output_count.
`timescale 1ns/1ps
module tb_lane_sipo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int total = 0;
  int bad   = 0;

  logic       a_iv;
  logic [0:0] a_id;
  logic       a_or;
  logic       a_ir, a_ov;
  logic [7:0] a_od;
  logic       b_ir, b_ov;
  logic [7:0] b_od;
  logic       c_iv;
  logic [3:0] c_id;
  logic       c_or;
  logic       c_ir, c_ov;
  logic [7:0] c_od;
`ifdef LANE_SIPO_LAST_EN
  logic       a_last;
  logic [3:0] a_cnt, b_cnt;
  logic       c_last;
  logic [1:0] c_cnt;
`endif

  lane_sipo #(.IN_BITS(1), .BEATS(8), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst),
    .input_valid(a_iv), .input_data(a_id), .input_ready(a_ir),
`ifdef LANE_SIPO_LAST_EN
    .input_last(a_last), .output_count(a_cnt),
`endif
    .output_valid(a_ov), .output_data(a_od), .output_ready(a_or)
  );

  lane_sipo #(.IN_BITS(1), .BEATS(8), .MSB_FIRST(0)) u_b (
    .clk(clk), .rst(rst),
    .input_valid(a_iv), .input_data(a_id), .input_ready(b_ir),
`ifdef LANE_SIPO_LAST_EN
    .input_last(a_last), .output_count(b_cnt),
`endif
    .output_valid(b_ov), .output_data(b_od), .output_ready(a_or)
  );

  lane_sipo #(.IN_BITS(4), .BEATS(2), .MSB_FIRST(1)) u_c (
    .clk(clk), .rst(rst),
    .input_valid(c_iv), .input_data(c_id), .input_ready(c_ir),
`ifdef LANE_SIPO_LAST_EN
    .input_last(c_last), .output_count(c_cnt),
`endif
    .output_valid(c_ov), .output_data(c_od), .output_ready(c_or)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_iv = 1'b0; a_id = 1'b0; a_or = 1'b0;
    c_iv = 1'b0; c_id = 4'h0; c_or = 1'b0;
`ifdef LANE_SIPO_LAST_EN
    a_last = 1'b0; c_last = 1'b0;
`endif
    #2 rst = 1'b0;
    #1;
    total++; if (a_ov !== 1'b0)  begin bad++; $display("FAIL reset_a_ov got=%0h want=0", a_ov); end
    total++; if (a_od !== 8'h00) begin bad++; $display("FAIL reset_a_od got=%0h want=00", a_od); end
    total++; if (a_ir !== 1'b1)  begin bad++; $display("FAIL reset_a_ir got=%0h want=1", a_ir); end
    total++; if (b_ov !== 1'b0)  begin bad++; $display("FAIL reset_b_ov got=%0h want=0", b_ov); end
    total++; if (b_od !== 8'h00) begin bad++; $display("FAIL reset_b_od got=%0h want=00", b_od); end
    total++; if (c_ov !== 1'b0)  begin bad++; $display("FAIL reset_c_ov got=%0h want=0", c_ov); end
    total++; if (c_od !== 8'h00) begin bad++; $display("FAIL reset_c_od got=%0h want=00", c_od); end
    total++; if (c_ir !== 1'b1)  begin bad++; $display("FAIL reset_c_ir got=%0h want=1", c_ir); end
`ifdef LANE_SIPO_LAST_EN
    total++; if (a_cnt !== 4'd0) begin bad++; $display("FAIL reset_a_cnt got=%0d want=0", a_cnt); end
`endif
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Two words back to back: B2 then 69 (MSB-first), i.e. 4D then 96 LSB-first.
  task automatic test_msb_lsb();
    logic [7:0] w0;
    logic [7:0] w1;
    w0 = 8'hB2;
    w1 = 8'h69;
    a_or = 1'b1;
    for (int k = 0; k < 16; k++) begin
      a_iv = 1'b1;
      a_id = (k < 8) ? w0[7-k] : w1[15-k];
      tick();
      if (k == 8) begin
        total++; if (a_ov !== 1'b1)  begin bad++; $display("FAIL word0_a_ov got=%0h want=1", a_ov); end
        total++; if (a_od !== 8'hB2) begin bad++; $display("FAIL word0_a_od got=%0h want=b2", a_od); end
        total++; if (b_ov !== 1'b1)  begin bad++; $display("FAIL word0_b_ov got=%0h want=1", b_ov); end
        total++; if (b_od !== 8'h4D) begin bad++; $display("FAIL word0_b_od got=%0h want=4d", b_od); end
      end else begin
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL b2b_idle_a_ov beat=%0d got=%0h want=0", k, a_ov); end
      end
    end
    a_iv = 1'b0;
    tick();
    total++; if (a_ov !== 1'b1)  begin bad++; $display("FAIL word1_a_ov got=%0h want=1", a_ov); end
    total++; if (a_od !== 8'h69) begin bad++; $display("FAIL word1_a_od got=%0h want=69", a_od); end
    total++; if (b_od !== 8'h96) begin bad++; $display("FAIL word1_b_od got=%0h want=96", b_od); end
    tick();
    total++; if (a_ov !== 1'b0)  begin bad++; $display("FAIL word1_one_cycle got=%0h want=0", a_ov); end
  endtask

  task automatic test_backpressure();
    c_or = 1'b0;
    c_iv = 1'b1;
    c_id = 4'hA; tick();
    c_id = 4'h5; tick();
    c_id = 4'h3; tick();
    c_id = 4'hC; tick();
    total++; if (c_ov !== 1'b1)  begin bad++; $display("FAIL bp_full_ov got=%0h want=1", c_ov); end
    total++; if (c_od !== 8'hA5) begin bad++; $display("FAIL bp_full_od got=%0h want=a5", c_od); end
    total++; if (c_ir !== 1'b0)  begin bad++; $display("FAIL bp_full_ir got=%0h want=0", c_ir); end
    c_id = 4'hF; tick();
    total++; if (c_od !== 8'hA5) begin bad++; $display("FAIL bp_hold_od got=%0h want=a5", c_od); end
    total++; if (c_ov !== 1'b1)  begin bad++; $display("FAIL bp_hold_ov got=%0h want=1", c_ov); end
    total++; if (c_ir !== 1'b0)  begin bad++; $display("FAIL bp_hold_ir got=%0h want=0", c_ir); end
    c_iv = 1'b0;
    c_or = 1'b1;
    #1;
    total++; if (c_ir !== 1'b1)  begin bad++; $display("FAIL bp_comb_ir got=%0h want=1", c_ir); end
    tick();
    c_or = 1'b0;
    #1;
    total++; if (c_ov !== 1'b1)  begin bad++; $display("FAIL bp_next_ov got=%0h want=1", c_ov); end
    total++; if (c_od !== 8'h3C) begin bad++; $display("FAIL bp_next_od got=%0h want=3c", c_od); end
    total++; if (c_ir !== 1'b1)  begin bad++; $display("FAIL bp_next_ir got=%0h want=1", c_ir); end
    c_or = 1'b1;
    tick();
    total++; if (c_ov !== 1'b0)  begin bad++; $display("FAIL bp_drain_ov got=%0h want=0", c_ov); end
    c_or = 1'b0;
  endtask

`ifdef LANE_SIPO_LAST_EN
  task automatic test_last();
    a_or = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_iv = 1'b1; a_id = 1'b1; a_last = (k == 2);
      tick();
    end
    a_iv = 1'b0; a_last = 1'b0;
    tick();
    total++; if (a_ov !== 1'b1)  begin bad++; $display("FAIL last_ov got=%0h want=1", a_ov); end
    total++; if (a_od !== 8'hE0) begin bad++; $display("FAIL last_a_od got=%0h want=e0", a_od); end
    total++; if (a_cnt !== 4'd3) begin bad++; $display("FAIL last_a_cnt got=%0d want=3", a_cnt); end
    total++; if (b_od !== 8'h07) begin bad++; $display("FAIL last_b_od got=%0h want=07", b_od); end
    total++; if (b_cnt !== 4'd3) begin bad++; $display("FAIL last_b_cnt got=%0d want=3", b_cnt); end
    tick();
    total++; if (a_ov !== 1'b0)  begin bad++; $display("FAIL last_drain_ov got=%0h want=0", a_ov); end
    for (int k = 0; k < 8; k++) begin
      a_iv = 1'b1; a_id = 1'b1; a_last = (k == 7);
      tick();
    end
    a_iv = 1'b0; a_last = 1'b0;
    tick();
    total++; if (a_od !== 8'hFF) begin bad++; $display("FAIL full_a_od got=%0h want=ff", a_od); end
    total++; if (a_cnt !== 4'd8) begin bad++; $display("FAIL full_a_cnt got=%0d want=8", a_cnt); end
    tick();
  endtask
`endif

  // 64 continuous beats; word w carries the value (w*37+5) mod 256.
  task automatic test_stream();
    int words;
    logic [7:0] w;
    logic [7:0] exp_w;
    words = 0;
    a_or = 1'b1;
    for (int i = 0; i < 64; i++) begin
      w = 8'((i / 8) * 37 + 5);
      a_iv = 1'b1;
      a_id = w[7 - (i % 8)];
      total++; if (a_ir !== 1'b1) begin bad++; $display("FAIL stream_ir beat=%0d got=%0h want=1", i, a_ir); end
      tick();
      if (a_ov === 1'b1 && words < 8) begin
        exp_w = 8'(words * 37 + 5);
        total++; if (a_od !== exp_w) begin bad++; $display("FAIL stream_word%0d got=%0h want=%0h", words, a_od, exp_w); end
        words++;
      end
    end
    a_iv = 1'b0;
    for (int d = 0; d < 4; d++) begin
      tick();
      if (a_ov === 1'b1 && words < 8) begin
        exp_w = 8'(words * 37 + 5);
        total++; if (a_od !== exp_w) begin bad++; $display("FAIL stream_word%0d got=%0h want=%0h", words, a_od, exp_w); end
        words++;
      end
    end
    total++; if (words != 8) begin bad++; $display("FAIL stream_words got=%0d want=8", words); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    w = 8'hC3;
    a_or = 1'b0;
    for (int k = 0; k < 13; k++) begin
      a_iv = 1'b1;
      a_id = (k < 8) ? w[7-k] : 1'b0;
      tick();
    end
    a_iv = 1'b0;
    total++; if (a_ov !== 1'b1)  begin bad++; $display("FAIL mid_held_ov got=%0h want=1", a_ov); end
    total++; if (a_od !== 8'hC3) begin bad++; $display("FAIL mid_held_od got=%0h want=c3", a_od); end
    #2 rst = 1'b0;
    #1;
    total++; if (a_ov !== 1'b0)  begin bad++; $display("FAIL mid_rst_ov got=%0h want=0", a_ov); end
    total++; if (a_od !== 8'h00) begin bad++; $display("FAIL mid_rst_od got=%0h want=00", a_od); end
    total++; if (a_ir !== 1'b1)  begin bad++; $display("FAIL mid_rst_ir got=%0h want=1", a_ir); end
    tick();
    rst = 1'b1;
    a_or = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_iv = 1'b1; a_id = 1'b1;
      tick();
      if (k < 7) begin
        total++; if (a_ov !== 1'b0) begin bad++; $display("FAIL mid_fresh_ov beat=%0d got=%0h want=0", k, a_ov); end
      end
    end
    a_iv = 1'b0;
    tick();
    total++; if (a_ov !== 1'b1)  begin bad++; $display("FAIL mid_fresh_word_ov got=%0h want=1", a_ov); end
    total++; if (a_od !== 8'hFF) begin bad++; $display("FAIL mid_fresh_word_od got=%0h want=ff", a_od); end
    tick();
  endtask

  initial begin
    test_reset();
    test_msb_lsb();
    test_backpressure();
`ifdef LANE_SIPO_LAST_EN
    test_last();
`endif
    test_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
